// File: rtl/onehot_encoder_pipe.sv
// N-to-log2(N) request encoder with strict / fixed-priority / round-robin decode,
// one registered output stage behind a valid/ready handshake, and a saturating error counter.
module onehot_encoder_pipe #(
    parameter int N     = 8,
    parameter int W     = $clog2(N),
    parameter int MODE  = 0,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     w,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     y,
    output logic             y_zero,
    output logic             y_multi,
    output logic             y_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_cnt,
    input  logic             err_clr
);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [W-1:0]     y_p0;
    logic             zero_p0;
    logic             multi_p0;
    logic             err_p0;
    logic             seen;
    logic [W-1:0]     hi_idx;
    logic [N-1:0]     rot;
    logic [W-1:0]     first_k;
    logic [W:0]       rr_sum;
    logic [W-1:0]     rr_idx;
    logic [W-1:0]     ptr_q;
    logic [W-1:0]     ptr_nxt;
    logic             accept;

    logic [W-1:0]     y_p1;
    logic             zero_p1;
    logic             multi_p1;
    logic             err_p1;
    logic             vld_p1;
    logic [ERR_W-1:0] cnt_p1;

    // ---- stage p0: combinational decode of the incoming vector ----
    always_comb begin
        seen     = 1'b0;
        multi_p0 = 1'b0;
        hi_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (w[i]) begin
                if (seen) multi_p0 = 1'b1;
                seen   = 1'b1;
                hi_idx = W'(i);
            end
        end
        zero_p0 = !seen;
    end

    // Rotate so bit 0 is the pointer position; the lowest set bit of rot is the RR winner.
    always_comb begin
        rot     = N'({w, w} >> ptr_q);
        first_k = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) first_k = W'(k);
        end
        rr_sum = {1'b0, ptr_q} + {1'b0, first_k};
        rr_idx = (rr_sum >= (W+1)'(N)) ? W'(rr_sum - (W+1)'(N)) : W'(rr_sum);
    end

    always_comb begin
        y_p0   = '0;
        err_p0 = 1'b0;
        case (MODE)
            0: begin
                err_p0 = zero_p0 || multi_p0;
                if (!err_p0) y_p0 = hi_idx;
            end
            1: begin
                err_p0 = zero_p0;
                if (!zero_p0) y_p0 = hi_idx;
            end
            default: begin
                err_p0 = zero_p0;
                if (!zero_p0) y_p0 = rr_idx;
            end
        endcase
    end

    assign ptr_nxt  = (y_p0 == W'(N - 1)) ? '0 : y_p0 + 1'b1;
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // ---- stage p1: registered result, RR pointer and error counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            y_p1     <= '0;
            zero_p1  <= 1'b0;
            multi_p1 <= 1'b0;
            err_p1   <= 1'b0;
            ptr_q    <= '0;
            cnt_p1   <= '0;
        end else begin
            if (accept) begin
                vld_p1   <= 1'b1;
                y_p1     <= y_p0;
                zero_p1  <= zero_p0;
                multi_p1 <= multi_p0;
                err_p1   <= err_p0;
                if (MODE == 2 && !zero_p0) ptr_q <= ptr_nxt;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (err_clr) begin
                cnt_p1 <= '0;
            end else if (accept && err_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    assign y         = y_p1;
    assign y_zero    = zero_p1;
    assign y_multi   = multi_p1;
    assign y_err     = err_p1;
    assign out_valid = vld_p1;
    assign err_cnt   = cnt_p1;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: four instances (strict, priority, round-robin, N=5 round-robin)
// share one stimulus stream and are checked against a behavioural model.
module tb_onehot_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] w = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;

    logic       ir0, ir1, ir2, ir3;
    logic [2:0] y0, y1, y2, y3;
    logic       z0, z1, z2, z3, m0, m1, m2, m3, e0, e1, e2, e3;
    logic       ov0, ov1, ov2, ov3;
    logic [1:0] cnt0;
    logic [7:0] cnt1, cnt2;
    logic [3:0] cnt3;

    always #5 clk = ~clk;

    onehot_encoder_pipe #(.N(8), .MODE(0), .ERR_W(2)) u0 (
        .clk(clk), .rst(rst), .w(w), .in_valid(in_valid), .in_ready(ir0), .y(y0),
        .y_zero(z0), .y_multi(m0), .y_err(e0), .out_valid(ov0), .out_ready(out_ready),
        .err_cnt(cnt0), .err_clr(err_clr));
    onehot_encoder_pipe #(.N(8), .MODE(1), .ERR_W(8)) u1 (
        .clk(clk), .rst(rst), .w(w), .in_valid(in_valid), .in_ready(ir1), .y(y1),
        .y_zero(z1), .y_multi(m1), .y_err(e1), .out_valid(ov1), .out_ready(out_ready),
        .err_cnt(cnt1), .err_clr(err_clr));
    onehot_encoder_pipe #(.N(8), .MODE(2), .ERR_W(8)) u2 (
        .clk(clk), .rst(rst), .w(w), .in_valid(in_valid), .in_ready(ir2), .y(y2),
        .y_zero(z2), .y_multi(m2), .y_err(e2), .out_valid(ov2), .out_ready(out_ready),
        .err_cnt(cnt2), .err_clr(err_clr));
    onehot_encoder_pipe #(.N(5), .MODE(2), .ERR_W(4)) u3 (
        .clk(clk), .rst(rst), .w(w[4:0]), .in_valid(in_valid), .in_ready(ir3), .y(y3),
        .y_zero(z3), .y_multi(m3), .y_err(e3), .out_valid(ov3), .out_ready(out_ready),
        .err_cnt(cnt3), .err_clr(err_clr));

    logic       o_ir[4], o_ov[4], o_z[4], o_m[4], o_e[4];
    logic [7:0] o_y[4], o_cnt[4];
    assign o_ir  = '{ir0, ir1, ir2, ir3};
    assign o_ov  = '{ov0, ov1, ov2, ov3};
    assign o_z   = '{z0, z1, z2, z3};
    assign o_m   = '{m0, m1, m2, m3};
    assign o_e   = '{e0, e1, e2, e3};
    assign o_y   = '{{5'b0, y0}, {5'b0, y1}, {5'b0, y2}, {5'b0, y3}};
    assign o_cnt = '{{6'b0, cnt0}, cnt1, cnt2, {4'b0, cnt3}};

    int NN[4]   = '{8, 8, 8, 5};
    int MD[4]   = '{0, 1, 2, 2};
    int CMAX[4] = '{3, 255, 255, 15};

    bit m_ov[4], m_z[4], m_m[4], m_e[4];
    int m_y[4], m_cnt[4], m_ptr[4];

    int n_total = 0;
    int n_pass  = 0;

    function automatic logic [11:0] obs(input int i);
        return {o_ov[i], o_y[i], o_z[i], o_m[i], o_e[i]};
    endfunction

    // Reference decode straight from the mode rules: count bits, scan for highest / next-from-pointer.
    function automatic void enc(input int n, input int mode, input logic [7:0] wv, input int ptr,
                                output int ey, output bit ez, output bit em, output bit ee);
        int ones = 0;
        int hi = 0;
        int first = -1;
        for (int i = 0; i < n; i++) if (wv[i]) begin ones++; hi = i; end
        for (int k = 0; k < n; k++) if (first < 0 && wv[(ptr + k) % n]) first = (ptr + k) % n;
        ez = (ones == 0);
        em = (ones > 1);
        case (mode)
            0:       begin ee = (ones != 1); ey = (ones == 1) ? hi : 0; end
            1:       begin ee = ez; ey = ez ? 0 : hi; end
            default: begin ee = ez; ey = ez ? 0 : first; end
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, return at the next negedge.
    task automatic step(input logic [7:0] wv, input logic iv, input logic ordy,
                        input logic clr, input logic r);
        bit acc[4];
        int ey;
        bit ez, em, ee;
        w = wv; in_valid = iv; out_ready = ordy; err_clr = clr; rst = r;
        for (int i = 0; i < 4; i++) acc[i] = iv && (!m_ov[i] || ordy);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                m_ov[i] = 0; m_y[i] = 0; m_z[i] = 0; m_m[i] = 0; m_e[i] = 0;
                m_cnt[i] = 0; m_ptr[i] = 0;
            end else begin
                enc(NN[i], MD[i], wv, m_ptr[i], ey, ez, em, ee);
                if (acc[i]) begin
                    m_ov[i] = 1; m_y[i] = ey; m_z[i] = ez; m_m[i] = em; m_e[i] = ee;
                    if (MD[i] == 2 && !ez) m_ptr[i] = (ey + 1) % NN[i];
                end else if (ordy) begin
                    m_ov[i] = 0;
                end
                if (clr) m_cnt[i] = 0;
                else if (acc[i] && ee && m_cnt[i] < CMAX[i]) m_cnt[i]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(8'h00, 0, 1, 0, 1);
        step(8'h00, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (obs(i) !== 12'h000 || o_cnt[i] !== 8'd0 || o_ir[i] !== 1'b1)
                $display("FAIL reset inst%0d got obs=%h cnt=%0d ir=%b want obs=000 cnt=0 ir=1",
                         i, obs(i), o_cnt[i], o_ir[i]);
            else n_pass++;
        end
    endtask

    task automatic test_onehot();
        logic [7:0] vec[3] = '{8'h01, 8'h04, 8'h80};
        logic [7:0] idx[3] = '{8'd0, 8'd2, 8'd7};
        step(8'h00, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(vec[k], 1, 1, 0, 0);
            n_total++;
            if (obs(0) !== {1'b1, idx[k], 3'b000})
                $display("FAIL onehot_%0d got %h want %h", k, obs(0), {1'b1, idx[k], 3'b000});
            else n_pass++;
        end
        step(8'h00, 0, 1, 0, 0);
        n_total++;
        if (o_ov[0] !== 1'b0) $display("FAIL onehot_drain got ov=%b want 0", o_ov[0]);
        else n_pass++;
    endtask

    task automatic test_illegal();
        step(8'h00, 0, 1, 0, 1);
        step(8'h00, 1, 1, 0, 0);
        n_total++;
        if (obs(0) !== {1'b1, 8'd0, 3'b101}) $display("FAIL illegal_zero got %h want %h", obs(0), {1'b1, 8'd0, 3'b101});
        else n_pass++;
        step(8'h06, 1, 1, 0, 0);
        n_total++;
        if (obs(0) !== {1'b1, 8'd0, 3'b011}) $display("FAIL illegal_multi got %h want %h", obs(0), {1'b1, 8'd0, 3'b011});
        else n_pass++;
        step(8'h00, 0, 1, 0, 0);
        n_total++;
        if (o_cnt[0] !== 8'd2) $display("FAIL illegal_cnt got %0d want 2", o_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_priority();
        step(8'h00, 0, 1, 0, 1);
        step(8'h16, 1, 0, 0, 0);
        n_total++;
        if (obs(1) !== {1'b1, 8'd4, 3'b010}) $display("FAIL prio_first got %h want %h", obs(1), {1'b1, 8'd4, 3'b010});
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step(8'h03, 1, 0, 0, 0);
            n_total++;
            if (obs(1) !== {1'b1, 8'd4, 3'b010} || o_ir[1] !== 1'b0)
                $display("FAIL prio_hold_%0d got %h ir=%b want %h ir=0", k, obs(1), o_ir[1], {1'b1, 8'd4, 3'b010});
            else n_pass++;
        end
        step(8'h03, 1, 1, 0, 0);
        n_total++;
        if (obs(1) !== {1'b1, 8'd1, 3'b010}) $display("FAIL prio_drain got %h want %h", obs(1), {1'b1, 8'd1, 3'b010});
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_y[5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        step(8'h00, 0, 1, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step(8'h0F, 1, 1, 0, 0);
            n_total++;
            if (obs(2) !== {1'b1, exp_y[k], 3'b010})
                $display("FAIL rr_%0d got %h want %h", k, obs(2), {1'b1, exp_y[k], 3'b010});
            else n_pass++;
        end
        step(8'h00, 1, 1, 0, 0);
        n_total++;
        if (obs(2) !== {1'b1, 8'd0, 3'b101}) $display("FAIL rr_zero got %h want %h", obs(2), {1'b1, 8'd0, 3'b101});
        else n_pass++;
        step(8'h0F, 1, 1, 0, 0);
        n_total++;
        if (obs(2) !== {1'b1, 8'd1, 3'b010}) $display("FAIL rr_after_zero got %h want %h", obs(2), {1'b1, 8'd1, 3'b010});
        else n_pass++;
    endtask

    task automatic test_saturation();
        step(8'h00, 0, 1, 0, 1);
        for (int k = 0; k < 5; k++) step(8'h00, 1, 1, 0, 0);
        n_total++;
        if (o_cnt[0] !== 8'd3) $display("FAIL sat_cnt got %0d want 3", o_cnt[0]);
        else n_pass++;
        step(8'h00, 1, 1, 1, 0);
        n_total++;
        if (o_cnt[0] !== 8'd0) $display("FAIL sat_clr got %0d want 0", o_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        step(8'h00, 0, 1, 0, 1);
        step(8'h30, 1, 1, 0, 0);
        step(8'h30, 1, 0, 0, 0);
        n_total++;
        if (obs(2) !== {1'b1, 8'd4, 3'b010} || o_cnt[0] !== 8'd1)
            $display("FAIL midrst_pre got %h cnt0=%0d want %h cnt0=1", obs(2), o_cnt[0], {1'b1, 8'd4, 3'b010});
        else n_pass++;
        step(8'hFF, 1, 0, 0, 1);
        n_total++;
        if (o_ov[2] !== 1'b0 || o_cnt[0] !== 8'd0)
            $display("FAIL midrst_clear got ov=%b cnt0=%0d want ov=0 cnt0=0", o_ov[2], o_cnt[0]);
        else n_pass++;
        step(8'hFF, 1, 1, 0, 0);
        n_total++;
        if (obs(2) !== {1'b1, 8'd0, 3'b010}) $display("FAIL midrst_ptr got %h want %h", obs(2), {1'b1, 8'd0, 3'b010});
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] wv;
        step(8'h00, 0, 1, 0, 1);
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 3))
                0:       wv = 8'h00;
                1:       wv = 8'h01 << $urandom_range(0, 7);
                2:       wv = 8'($urandom);
                default: wv = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
            endcase
            step(wv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 99) == 0));
            for (int i = 0; i < 4; i++) begin
                n_total++;
                if (o_ov[i] !== m_ov[i] || o_cnt[i] !== 8'(m_cnt[i]) || o_ir[i] !== (!m_ov[i] || out_ready))
                    $display("FAIL rand_ctl c%0d inst%0d got ov=%b cnt=%0d ir=%b want ov=%b cnt=%0d ir=%b",
                             c, i, o_ov[i], o_cnt[i], o_ir[i], m_ov[i], m_cnt[i], !m_ov[i] || out_ready);
                else n_pass++;
                if (m_ov[i]) begin
                    n_total++;
                    if (obs(i) !== {1'b1, 8'(m_y[i]), m_z[i], m_m[i], m_e[i]})
                        $display("FAIL rand_data c%0d inst%0d got %h want %h",
                                 c, i, obs(i), {1'b1, 8'(m_y[i]), m_z[i], m_m[i], m_e[i]});
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_illegal();
        test_priority();
        test_round_robin();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
Parametrised N-to-log2(N) encoder with a registered output stage and a valid/ready handshake on both sides. It is the next generation of the team's 4-to-2 one-hot encoder. It adds selectable decode modes (strict one-hot, fixed priority, round-robin priority), explicit zero/multi-hot flags in place of an X output, and a saturating error counter. It sits between request-vector producers (interrupt lines, arbiter requests) and downstream logic that consumes a binary index.

Parameters:
N, 8, input vector width; legal values 2..64.
W, $clog2(N), output code width; derived, not overridden.
MODE, 0, 0 = strict one-hot, 1 = fixed priority (highest index wins), 2 = round-robin priority.
ERR_W, 8, error counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
w  in  N  request/one-hot vector.
in_valid  in  1  `w` is valid this cycle.
in_ready  out  1  block can accept `w`.
y  out  W  encoded index.
y_zero  out  1  accepted vector had no bits set.
y_multi  out  1  accepted vector had more than one bit set.
y_err  out  1  accepted vector is illegal for MODE.
out_valid  out  1  `y`/flags hold an unconsumed result.
out_ready  in  1  consumer takes the result.
err_cnt  out  ERR_W  saturating count of accepted vectors with `y_err` = 1.
err_clr  in  1  clears `err_cnt`.

Behaviour:
- Reset, clocked with `rst` = 1: `out_valid` = 0, `y` = 0, `y_zero` = 0, `y_multi` = 0, `y_err` = 0, `err_cnt` = 0, RR pointer `ptr` = 0. `rst` overrides all other inputs, including mid-transfer; a pending result is discarded.
- `in_ready` = !out_valid || out_ready. It is combinational; there is no combinational path from `w` or `in_valid` to any output.
- Accept = in_valid && in_ready. The result is registered and appears with `out_valid` = 1 on the cycle after accept (latency 1).
- Throughput is 1 per cycle while `out_ready` = 1. If `out_valid` = 1 and `out_ready` = 0, `y` and all flags hold stable and `in_ready` = 0.
- If `out_ready` = 1 with no accept, `out_valid` falls to 0 next cycle. If accept and drain happen in the same cycle, the new result replaces the old one with `out_valid` staying 1.
- `y_zero` = (w == 0) and `y_multi` = (popcount(w) > 1), in every mode.
- MODE 0: exactly one bit set gives `y` = its index. Otherwise `y` = 0 and `y_err` = 1. `y_err` = y_zero || y_multi.
- MODE 1: `y` = index of the highest set bit. `y_err` = y_zero, with `y` = 0 in that case. Multi-hot is legal; `y_multi` is informational only.
- MODE 2: search indices ptr, ptr+1, ... wrapping mod N; `y` = first set bit found. On accept with w != 0, `ptr` <= (y + 1) mod N; the wrap from N-1 goes to 0. A zero vector leaves `ptr` unchanged and gives `y_err` = 1, `y` = 0. `ptr` advances only on accept, never on stall.
- `err_cnt`: increments by 1 on each accept whose computed `y_err` = 1 and saturates at 2^ERR_W - 1. `err_clr` sets it to 0 next cycle. `err_clr` wins over a simultaneous increment.
- For non-power-of-2 N, `y` never exceeds N-1.

Test Plan:
- Reset and basic one-hot, MODE 0, N=8, `out_ready` = 1: send w = 0x01, 0x04, 0x80 back-to-back → `y` = 0, 2, 7 on consecutive cycles starting 1 cycle after the first accept; all flags 0.
- Illegal vectors, MODE 0: w = 0x00 then 0x06 → first result `y` = 0, `y_zero` = 1, `y_err` = 1; second result `y` = 0, `y_multi` = 1, `y_err` = 1; `err_cnt` = 2.
- Priority and backpressure, MODE 1: w = 0x16 accepted while `out_ready` = 0 for 3 cycles → `y` = 4, `y_multi` = 1, `y_err` = 0 held stable; `in_ready` = 0 throughout; the next w = 0x03 is accepted on the drain cycle and gives `y` = 1.
- Round-robin fairness, MODE 2: w = 0x0F held for 5 accepts → `y` = 0, 1, 2, 3, 0. Then w = 0x00 → `y_err` = 1 and `ptr` unchanged, so the next w = 0x0F gives `y` = 1.
- Counter saturation and clear, ERR_W = 2: 5 zero-vector accepts → `err_cnt` = 3. Assert `err_clr` together with a zero-vector accept → `err_cnt` = 0.
- Mid-operation reset: assert `rst` while `out_valid` = 1, `out_ready` = 0, `ptr` = 5 → next cycle `out_valid` = 0, `err_cnt` = 0, and in MODE 2 the next w = 0xFF gives `y` = 0.
